// File: rtl/selen_wb_master_bridge_pkg.sv
// Shared definitions for the Selen Wishbone master bridge.
//   ST_*      : FSM state encodings (IDLE, BUS, BACKOFF, RESP)
//   cnt_width : bit width needed to hold a counter value 0..max_val
package selen_wb_master_bridge_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUS     = 2'd1;
   localparam logic [1:0] ST_BACKOFF = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   // Never returns 0 so a counter always has at least one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/selen_wb_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val (has priority over i_en)
//   i_load_val  : value to load
//   i_en        : decrement by one, saturating at zero
//   o_done_c    : counter is zero (combinational from the count register)
module selen_wb_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_done_c
);

   logic [W-1:0] r_cnt;

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/selen_wb_master_bridge.sv
// Wishbone B4 classic-cycle initiator: one core load/store in, one bus cycle
// (with bounded RTY re-issue and a bus timeout) out, exactly one response back.
//   clk, rst_n                         : clock, async active-low reset
//   req_val/req_rdy/req_addr/req_we/
//   req_wdata/req_be                   : core request handshake and payload
//   resp_val/resp_rdata/resp_err       : one-cycle response pulse
//   wb_*_o / wb_*_i                    : Wishbone initiator port
module selen_wb_master_bridge
   import selen_wb_master_bridge_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned RTY_MAX = 4,
   parameter int unsigned RTY_GAP = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_val,
   output logic            req_rdy,
   input  logic [AW-1:0]   req_addr,
   input  logic            req_we,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_be,
   output logic            resp_val,
   output logic [DW-1:0]   resp_rdata,
   output logic            resp_err,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   input  logic [DW-1:0]   wb_dat_i,
   output logic            wb_we_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic            wb_stb_o,
   output logic            wb_cyc_o,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i
);

   localparam int unsigned BE_W  = DW / 8;
   localparam int unsigned TO_W  = cnt_width(TIMEOUT);
   localparam int unsigned GAP_W = cnt_width(RTY_GAP);
   localparam int unsigned RTY_W = cnt_width(RTY_MAX);

   logic [1:0]      r_state;
   logic            r_rdy;
   logic            r_cyc;
   logic            r_we;
   logic [AW-1:0]   r_adr;
   logic [DW-1:0]   r_dat;
   logic [BE_W-1:0] r_sel;
   logic            r_resp_val;
   logic [DW-1:0]   r_resp_rdata;
   logic            r_resp_err;
   logic [RTY_W-1:0] r_rty_cnt;

   logic [1:0]      w_state_nxt;
   logic            w_rdy_nxt;
   logic            w_cyc_nxt;
   logic            w_resp_val_nxt;
   logic [DW-1:0]   w_resp_rdata_nxt;
   logic            w_resp_err_nxt;
   logic [RTY_W-1:0] w_rty_nxt;
   logic            w_latch;
   logic            w_to_load;
   logic            w_gap_load;
   logic            w_to_done;
   logic            w_gap_done;

   // Timeout: loaded with TIMEOUT-1 on every entry to BUS, reaches zero in
   // the TIMEOUT-th unterminated bus cycle.
   selen_wb_timer #(.W(TO_W)) u_timeout (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_to_load),
      .i_load_val (TO_W'(TIMEOUT - 1)),
      .i_en       (r_state == ST_BUS),
      .o_done_c   (w_to_done)
   );

   // Backoff gap: loaded with RTY_GAP-1 on RTY, zero in the last idle cycle.
   selen_wb_timer #(.W(GAP_W)) u_gap (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_gap_load),
      .i_load_val (GAP_W'(RTY_GAP - 1)),
      .i_en       (r_state == ST_BACKOFF),
      .o_done_c   (w_gap_done)
   );

   // Next state and next registered outputs
   always_comb begin
      w_state_nxt      = r_state;
      w_rdy_nxt        = 1'b0;
      w_cyc_nxt        = 1'b0;
      w_resp_val_nxt   = 1'b0;
      w_resp_rdata_nxt = '0;
      w_resp_err_nxt   = 1'b0;
      w_rty_nxt        = r_rty_cnt;
      w_latch          = 1'b0;
      w_to_load        = 1'b0;
      w_gap_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_rdy_nxt = 1'b1;
            // r_rdy is still low in the first cycle after reset release
            if (req_val && r_rdy) begin
               w_latch     = 1'b1;
               w_to_load   = 1'b1;
               w_cyc_nxt   = 1'b1;
               w_rdy_nxt   = 1'b0;
               w_state_nxt = ST_BUS;
            end
         end
         ST_BUS: begin
            w_cyc_nxt = 1'b1;
            // Termination priority: err > ack > rty > timeout
            if (wb_err_i) begin
               w_cyc_nxt      = 1'b0;
               w_resp_val_nxt = 1'b1;
               w_resp_err_nxt = 1'b1;
               w_state_nxt    = ST_RESP;
            end else if (wb_ack_i) begin
               w_cyc_nxt        = 1'b0;
               w_resp_val_nxt   = 1'b1;
               w_resp_rdata_nxt = r_we ? '0 : wb_dat_i;
               w_state_nxt      = ST_RESP;
            end else if (wb_rty_i) begin
               w_cyc_nxt = 1'b0;
               if (r_rty_cnt < RTY_W'(RTY_MAX)) begin
                  w_rty_nxt   = r_rty_cnt + RTY_W'(1);
                  w_gap_load  = 1'b1;
                  w_state_nxt = ST_BACKOFF;
               end else begin
                  w_resp_val_nxt = 1'b1;
                  w_resp_err_nxt = 1'b1;
                  w_state_nxt    = ST_RESP;
               end
            end else if (w_to_done) begin
               w_cyc_nxt      = 1'b0;
               w_resp_val_nxt = 1'b1;
               w_resp_err_nxt = 1'b1;
               w_state_nxt    = ST_RESP;
            end
         end
         ST_BACKOFF: begin
            if (w_gap_done) begin
               w_cyc_nxt   = 1'b1;
               w_to_load   = 1'b1;
               w_state_nxt = ST_BUS;
            end
         end
         ST_RESP: begin
            w_rty_nxt   = '0;
            w_rdy_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, request latch and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_rdy        <= 1'b0;
         r_cyc        <= 1'b0;
         r_we         <= 1'b0;
         r_adr        <= '0;
         r_dat        <= '0;
         r_sel        <= '0;
         r_resp_val   <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_rty_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rdy        <= w_rdy_nxt;
         r_cyc        <= w_cyc_nxt;
         r_resp_val   <= w_resp_val_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
         r_rty_cnt    <= w_rty_nxt;
         if (w_latch) begin
            r_we  <= req_we;
            r_adr <= req_addr;
            r_dat <= req_wdata;
            r_sel <= req_be;
         end
      end
   end

   assign req_rdy    = r_rdy;
   assign resp_val   = r_resp_val;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign wb_adr_o   = r_adr;
   assign wb_dat_o   = r_dat;
   assign wb_we_o    = r_we;
   assign wb_sel_o   = r_sel;
   assign wb_cyc_o   = r_cyc;
   assign wb_stb_o   = r_cyc;

endmodule

// File: tb/tb_selen_wb_master_bridge.sv
// Self-checking bench for selen_wb_master_bridge: directed vector table,
// random transactions scored against a transaction-level reference model,
// and hand-written reset sequences.
module tb_selen_wb_master_bridge;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int RTY_MAX = 4;
   localparam int RTY_GAP = 2;
   localparam int TIMEOUT = 255;
   localparam int MAXA    = 8;

   // Slave behaviour per bus attempt
   localparam logic [2:0] T_ACK  = 3'd0;
   localparam logic [2:0] T_ERR  = 3'd1;
   localparam logic [2:0] T_RTY  = 3'd2;
   localparam logic [2:0] T_NONE = 3'd3;
   localparam logic [2:0] T_AE   = 3'd4;
   localparam logic [2:0] T_AR   = 3'd5;
   localparam logic [2:0] T_ALL  = 3'd6;

   typedef struct packed {
      logic [31:0]           addr;
      logic                  we;
      logic [31:0]           wdata;
      logic [3:0]            be;
      logic [31:0]           sdata;
      logic [3:0]            n_att;
      logic [MAXA-1:0][7:0]  ws;
      logic [MAXA-1:0][2:0]  term;
      logic [15:0]           exp_cyc;
      logic [3:0]            exp_att;
      logic [15:0]           exp_lat;
      logic                  exp_err;
      logic [31:0]           exp_rdata;
   } vec_t;

   logic            clk;
   logic            rst_n;
   logic            req_val;
   logic            req_rdy;
   logic [AW-1:0]   req_addr;
   logic            req_we;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_be;
   logic            resp_val;
   logic [DW-1:0]   resp_rdata;
   logic            resp_err;
   logic [AW-1:0]   wb_adr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [DW-1:0]   wb_dat_i;
   logic            wb_we_o;
   logic [DW/8-1:0] wb_sel_o;
   logic            wb_stb_o;
   logic            wb_cyc_o;
   logic            wb_ack_i;
   logic            wb_err_i;
   logic            wb_rty_i;

   int checks = 0;
   int errors = 0;

   selen_wb_master_bridge #(
      .AW(AW), .DW(DW), .RTY_MAX(RTY_MAX), .RTY_GAP(RTY_GAP), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_val    (req_val),
      .req_rdy    (req_rdy),
      .req_addr   (req_addr),
      .req_we     (req_we),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_val   (resp_val),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_we_o    (wb_we_o),
      .wb_sel_o   (wb_sel_o),
      .wb_stb_o   (wb_stb_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .wb_rty_i   (wb_rty_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] sdata, input int n_att,
                               input logic [2:0] t_first, input logic [2:0] t_last,
                               input int ws);
      vec_t v;
      v       = '0;
      v.addr  = addr;
      v.we    = we;
      v.wdata = wdata;
      v.be    = be;
      v.sdata = sdata;
      v.n_att = 4'(n_att);
      for (int a = 0; a < n_att; a++) begin
         v.term[a] = (a == n_att - 1) ? t_last : t_first;
         v.ws[a]   = 8'(ws);
      end
      return v;
   endfunction

   function automatic vec_t ex(input vec_t v, input int cyc, input int att, input int lat,
                               input logic err, input logic [31:0] rd);
      vec_t r;
      r           = v;
      r.exp_cyc   = 16'(cyc);
      r.exp_att   = 4'(att);
      r.exp_lat   = 16'(lat);
      r.exp_err   = err;
      r.exp_rdata = rd;
      return r;
   endfunction

   // Transaction-level reference: walk the slave's attempt script and apply
   // the termination rules; latency = bus cycles + backoff cycles + 1.
   function automatic vec_t predict(input vec_t v);
      int          retries;
      int          cyc;
      int          gaps;
      int          att;
      logic        err;
      logic [31:0] rd;
      retries = 0; cyc = 0; gaps = 0; att = 0; err = 1'b1; rd = '0;
      for (int a = 0; a < 16; a++) begin
         logic [2:0] t;
         int         w;
         att++;
         if (a >= int'(v.n_att)) begin
            cyc += TIMEOUT; err = 1'b1; break;
         end
         t = v.term[a];
         w = int'(v.ws[a]);
         if (t == T_NONE || w >= TIMEOUT) begin
            cyc += TIMEOUT; err = 1'b1; break;
         end
         cyc += w + 1;
         if (t == T_ERR || t == T_AE || t == T_ALL) begin
            err = 1'b1; break;
         end
         if (t == T_ACK || t == T_AR) begin
            err = 1'b0; rd = v.we ? 32'h0 : v.sdata; break;
         end
         if (retries < RTY_MAX) begin
            retries++; gaps += RTY_GAP;
         end else begin
            err = 1'b1; break;
         end
      end
      return ex(v, cyc, att, cyc + gaps + 1, err, rd);
   endfunction

   // Issue one request, play the slave script, and score the outcome.
   task automatic run_txn(input vec_t v);
      int   lat;
      int   cyc_cnt;
      int   att_seen;
      int   c;
      int   ai;
      bit   prev;
      bit   stable_ok;
      bit   busy_ok;
      bit   got;
      logic [2:0] tm;
      lat = 0; cyc_cnt = 0; att_seen = 0; c = 0;
      prev = 1'b0; stable_ok = 1'b1; busy_ok = 1'b1; got = 1'b0;
      for (int k = 0; k < 10 && !req_rdy; k++) @(negedge clk);
      chk("accept_rdy", 32'(req_rdy), 32'd1);
      req_val   = 1'b1;
      req_addr  = v.addr;
      req_we    = v.we;
      req_wdata = v.wdata;
      req_be    = v.be;
      @(posedge clk);
      @(negedge clk);
      // Scramble the request bus: the bridge must be using its latched copy
      req_val   = 1'b0;
      req_addr  = $urandom;
      req_we    = 1'($urandom);
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      lat = 1;
      while (!got && lat <= int'(v.exp_lat) + 20) begin
         if (resp_val) begin
            got = 1'b1;
         end else begin
            if (req_rdy) busy_ok = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            wb_dat_i = $urandom;
            if (wb_cyc_o) begin
               cyc_cnt++;
               if (wb_stb_o !== 1'b1 || wb_adr_o !== v.addr || wb_we_o !== v.we ||
                   wb_sel_o !== v.be || wb_dat_o !== v.wdata)
                  stable_ok = 1'b0;
               if (!prev) begin att_seen++; c = 0; end
               else c++;
               ai = att_seen - 1;
               if (ai < int'(v.n_att) && ai < MAXA && c == int'(v.ws[ai])) begin
                  tm = v.term[ai];
                  case (tm)
                     T_ACK: wb_ack_i = 1'b1;
                     T_ERR: wb_err_i = 1'b1;
                     T_RTY: wb_rty_i = 1'b1;
                     T_AE:  begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                     T_AR:  begin wb_ack_i = 1'b1; wb_rty_i = 1'b1; end
                     T_ALL: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1; end
                     default: ;
                  endcase
                  if (wb_ack_i) wb_dat_i = v.sdata;
               end
            end else begin
               if (wb_stb_o) stable_ok = 1'b0;
               // Terminations outside a bus cycle must be ignored
               wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom); wb_rty_i = 1'($urandom);
            end
            prev = wb_cyc_o;
            @(negedge clk);
            lat++;
         end
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (!got) begin
         chk("resp_seen", 32'd0, 32'd1);
      end else begin
         chk("resp_lat",   32'(lat),        32'(v.exp_lat));
         chk("resp_err",   32'(resp_err),   32'(v.exp_err));
         chk("resp_rdata", resp_rdata,      v.exp_rdata);
         chk("cyc_at_resp", 32'(wb_cyc_o),  32'd0);
      end
      chk("bus_cycles", 32'(cyc_cnt),   32'(v.exp_cyc));
      chk("attempts",   32'(att_seen),  32'(v.exp_att));
      chk("stable",     32'(stable_ok), 32'd1);
      chk("rdy_busy",   32'(busy_ok),   32'd1);
      @(negedge clk);
      chk("resp_single", 32'(resp_val), 32'd0);
      chk("rdy_after",   32'(req_rdy),  32'd1);
   endtask

   vec_t tbl [9];
   vec_t v;

   initial begin
      rst_n = 1'b0; req_val = 1'b0; req_addr = '0; req_we = 1'b0;
      req_wdata = '0; req_be = '0; wb_dat_i = '0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

      tbl[0] = ex(mk(32'h0000_2004, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, T_ACK, T_ACK, 0),
                  1, 1, 2, 1'b0, 32'hDEAD_BEEF);
      tbl[1] = ex(mk(32'h0000_1008, 1'b1, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 1, T_ACK, T_ACK, 3),
                  4, 1, 5, 1'b0, 32'h0);
      tbl[2] = ex(mk(32'h0000_2010, 1'b0, 32'h0, 4'hF, 32'hA5A5_0001, 3, T_RTY, T_ACK, 0),
                  3, 3, 8, 1'b0, 32'hA5A5_0001);
      tbl[3] = ex(mk(32'h0000_2014, 1'b1, 32'hCAFE_0000, 4'hF, 32'h0, 5, T_RTY, T_RTY, 0),
                  5, 5, 14, 1'b1, 32'h0);
      tbl[4] = ex(mk(32'h0000_2018, 1'b0, 32'h0, 4'hF, 32'h1111_2222, 5, T_RTY, T_ACK, 0),
                  5, 5, 14, 1'b0, 32'h1111_2222);
      tbl[5] = ex(mk(32'h0000_3000, 1'b0, 32'h0, 4'hF, 32'h5555_5555, 1, T_NONE, T_NONE, 0),
                  255, 1, 256, 1'b1, 32'h0);
      tbl[6] = ex(mk(32'h0000_2020, 1'b0, 32'h0, 4'hF, 32'h7777_8888, 1, T_AE, T_AE, 1),
                  2, 1, 3, 1'b1, 32'h0);
      tbl[7] = ex(mk(32'h0000_2024, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, 1, T_AR, T_AR, 0),
                  1, 1, 2, 1'b0, 32'h0BAD_F00D);
      tbl[8] = ex(mk(32'h0000_2028, 1'b1, 32'h9999_0000, 4'b1000, 32'h0, 1, T_ERR, T_ERR, 2),
                  3, 1, 4, 1'b1, 32'h0);

      // Reset values
      #12;
      chk("rst_rdy",   32'(req_rdy),  32'd0);
      chk("rst_cyc",   32'(wb_cyc_o), 32'd0);
      chk("rst_stb",   32'(wb_stb_o), 32'd0);
      chk("rst_resp",  32'(resp_val), 32'd0);
      chk("rst_adr",   wb_adr_o,      32'd0);
      chk("rst_rdata", resp_rdata,    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_post_rst", 32'(req_rdy), 32'd1);

      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      // Reset during a bus wait-state: bus drops at once, no response follows
      @(negedge clk);
      req_val = 1'b1; req_addr = 32'h0000_3000; req_we = 1'b0; req_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_cyc_before", 32'(wb_cyc_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_cyc_async", 32'(wb_cyc_o), 32'd0);
      chk("mid_stb_async", 32'(wb_stb_o), 32'd0);
      chk("mid_rdy_async", 32'(req_rdy),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rdy_release", 32'(req_rdy), 32'd1);
      begin
         bit quiet;
         quiet = 1'b1;
         for (int k = 0; k < 300; k++) begin
            if (resp_val || wb_cyc_o) quiet = 1'b0;
            @(negedge clk);
         end
         chk("mid_no_resp", 32'(quiet), 32'd1);
      end

      // Random transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         int r;
         v = mk($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom,
                $urandom_range(1, 6), T_ACK, T_ACK, 0);
         for (int a = 0; a < int'(v.n_att); a++) begin
            r = $urandom_range(0, 99);
            v.ws[a] = 8'($urandom_range(0, 3));
            if      (r < 45) v.term[a] = T_RTY;
            else if (r < 70) v.term[a] = T_ACK;
            else if (r < 80) v.term[a] = T_ERR;
            else if (r < 86) v.term[a] = T_AE;
            else if (r < 92) v.term[a] = T_AR;
            else if (r < 98) v.term[a] = T_ALL;
            else             v.term[a] = T_NONE;
         end
         run_txn(predict(v));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
